sha3_digest_out: RTL and testbench

Downstream output stage of the SHA3 core. It takes the 1600-bit Keccak state (5×5×64 lane array, same lane layout as the input collector) once the permutation finishes. It truncates the state to the digest length selected by the mode, then streams the digest out as an AXI4-Stream master in DATA_WIDTH-bit beats with backpressure, TKEEP and TLAST.

---
 rtl/sha3_digest_out.sv | 136 +++++++++++++
 tb/tb_sha3_digest_out.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_digest_out.sv
// SHA3 digest output stage: truncates the final Keccak state to the
// selected digest length and streams it as an AXI4-Stream master.
module sha3_digest_out #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [0:4][0:4][63:0]     state_in,
   input  logic                      state_valid,
   input  logic [1:0]                mode,
   output logic [DATA_WIDTH-1:0]     M_TDATA,
   output logic [DATA_WIDTH/8-1:0]   M_TKEEP,
   output logic                      M_TVALID,
   input  logic                      M_TREADY,
   output logic                      M_TLAST,
   output logic                      busy,
   output logic                      overrun
);

   localparam int KW   = DATA_WIDTH / 8;
   localparam int N224 = (224 + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int N256 = (256 + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int N384 = (384 + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int N512 = (512 + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int PB   = (224 % DATA_WIDTH) / 8;
   localparam logic P224 = (224 % DATA_WIDTH) != 0;
   localparam logic [KW-1:0] KEEP_PART = KW'((64'd1 << PB) - 64'd1);

   typedef enum logic {IDLE, SEND} state_e;

   state_e       state_q, state_d;
   logic [511:0] sr_q, sr_d;
   logic [5:0]   cnt_q, cnt_d;
   logic         part_q, part_d;
   logic         ovr_q, ovr_d;

   logic [511:0] flat;
   logic [511:0] cap;
   logic [5:0]   cap_cnt;
   logic         cap_part;
   logic         hs;

   // Only the first eight lanes can ever reach a digest.
   for (genvar g = 0; g < 8; g++) begin : g_flat
      assign flat[64*g +: 64] = state_in[g % 5][g / 5];
   end

   always_comb begin
      cap      = '0;
      cap_cnt  = '0;
      cap_part = 1'b0;
      case (mode)
         2'd0: begin
            cap[223:0] = flat[223:0];
            cap_cnt    = 6'(N224 - 1);
            cap_part   = P224;
         end
         2'd1: begin
            cap[255:0] = flat[255:0];
            cap_cnt    = 6'(N256 - 1);
         end
         2'd2: begin
            cap[383:0] = flat[383:0];
            cap_cnt    = 6'(N384 - 1);
         end
         default: begin
            cap     = flat;
            cap_cnt = 6'(N512 - 1);
         end
      endcase
   end

   assign M_TVALID = (state_q == SEND);
   assign busy     = (state_q == SEND);
   assign M_TLAST  = M_TVALID && (cnt_q == 6'd0);
   assign M_TDATA  = M_TVALID ? sr_q[DATA_WIDTH-1:0] : '0;
   assign M_TKEEP  = !M_TVALID ? '0 :
                     (M_TLAST && part_q) ? KEEP_PART : '1;
   assign overrun  = ovr_q;
   assign hs       = M_TVALID && M_TREADY;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      part_d  = part_q;
      ovr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (state_valid) begin
               sr_d    = cap;
               cnt_d   = cap_cnt;
               part_d  = cap_part;
               state_d = SEND;
            end
         end
         default: begin
            if (hs && cnt_q == 6'd0) begin
               // A capture on the final handshake chains without a bubble.
               if (state_valid) begin
                  sr_d   = cap;
                  cnt_d  = cap_cnt;
                  part_d = cap_part;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (hs) begin
                  sr_d  = sr_q >> DATA_WIDTH;
                  cnt_d = cnt_q - 6'd1;
               end
               if (state_valid) begin
                  ovr_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         part_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         part_q  <= part_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_sha3_digest_out.sv
// Scoreboard bench for sha3_digest_out at DATA_WIDTH 16, 64 and 8.
// Expected beats are queued when a state is offered and popped per handshake.
module tb_sha3_digest_out;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [0:4][0:4][63:0] st;
   logic [1:0] md;
   logic sv16, sv64, sv8;
   logic r16, r64, r8;

   logic [15:0] d16;
   logic [1:0]  k16;
   logic        v16, l16, b16, o16;
   logic [63:0] d64;
   logic [7:0]  k64;
   logic        v64, l64, b64, o64;
   logic [7:0]  d8;
   logic [0:0]  k8;
   logic        v8, l8, b8, o8;

   sha3_digest_out #(.DATA_WIDTH(16)) u16 (
      .ACLK(clk), .ARESET(rst), .state_in(st), .state_valid(sv16),
      .mode(md), .M_TDATA(d16), .M_TKEEP(k16), .M_TVALID(v16),
      .M_TREADY(r16), .M_TLAST(l16), .busy(b16), .overrun(o16));

   sha3_digest_out #(.DATA_WIDTH(64)) u64 (
      .ACLK(clk), .ARESET(rst), .state_in(st), .state_valid(sv64),
      .mode(md), .M_TDATA(d64), .M_TKEEP(k64), .M_TVALID(v64),
      .M_TREADY(r64), .M_TLAST(l64), .busy(b64), .overrun(o64));

   sha3_digest_out #(.DATA_WIDTH(8)) u8 (
      .ACLK(clk), .ARESET(rst), .state_in(st), .state_valid(sv8),
      .mode(md), .M_TDATA(d8), .M_TKEEP(k8), .M_TVALID(v8),
      .M_TREADY(r8), .M_TLAST(l8), .busy(b8), .overrun(o8));

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   beat_t q16[$];
   beat_t q64[$];
   beat_t q8[$];

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic rand_st();
      for (int i = 0; i < 50; i++)
         st = (st << 32) | 1600'($urandom);
   endtask

   function automatic int qsize(input int dw);
      if (dw == 16) return q16.size();
      if (dw == 64) return q64.size();
      return q8.size();
   endfunction

   // Reference model: flatten, truncate, slice into beats.
   task automatic exp_push(input int dw);
      logic [511:0] fl, m;
      int d, n, rem;
      beat_t b;
      fl = {st[2][1], st[1][1], st[0][1], st[4][0],
            st[3][0], st[2][0], st[1][0], st[0][0]};
      case (md)
         2'd0: d = 224;
         2'd1: d = 256;
         2'd2: d = 384;
         default: d = 512;
      endcase
      m  = '1;
      m  = m >> (512 - d);
      fl = fl & m;
      n   = (d + dw - 1) / dw;
      rem = d % dw;
      for (int k = 0; k < n; k++) begin
         b.d = 64'(fl >> (dw * k));
         if (dw < 64) b.d = b.d & ((64'd1 << dw) - 64'd1);
         b.k = 8'((16'd1 << (dw / 8)) - 16'd1);
         if (k == n - 1 && rem != 0)
            b.k = 8'((16'd1 << (rem / 8)) - 16'd1);
         b.l = (k == n - 1);
         if (dw == 16) q16.push_back(b);
         else if (dw == 64) q64.push_back(b);
         else q8.push_back(b);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int dw);
      int lim;
      lim = 0;
      while (qsize(dw) != 0 && lim < 400) begin
         if (dw == 8) r8 = 1'($urandom_range(0, 1));
         step();
         lim++;
      end
      chk($sformatf("drain%0d_left", dw), 64'(qsize(dw)), 64'd0);
   endtask

   always @(negedge clk) begin : mon16
      beat_t e;
      if (!rst && v16 && r16) begin
         if (q16.size() == 0) begin
            chk("u16_extra_beat", 64'(v16), 64'd0);
         end else begin
            e = q16.pop_front();
            chk("u16_data", 64'(d16), e.d);
            chk("u16_keep", 64'(k16), 64'(e.k));
            chk("u16_last", 64'(l16), 64'(e.l));
         end
      end
   end

   always @(negedge clk) begin : mon64
      beat_t e;
      if (!rst && v64 && r64) begin
         if (q64.size() == 0) begin
            chk("u64_extra_beat", 64'(v64), 64'd0);
         end else begin
            e = q64.pop_front();
            chk("u64_data", d64, e.d);
            chk("u64_keep", 64'(k64), 64'(e.k));
            chk("u64_last", 64'(l64), 64'(e.l));
         end
      end
   end

   logic       p_stall = 1'b0;
   logic [7:0] p_d;
   logic       p_l;

   always @(negedge clk) begin : mon8
      beat_t e;
      if (!rst && p_stall && v8) begin
         chk("u8_stall_data", 64'(d8), 64'(p_d));
         chk("u8_stall_last", 64'(l8), 64'(p_l));
      end
      if (!rst && v8 && r8) begin
         if (q8.size() == 0) begin
            chk("u8_extra_beat", 64'(v8), 64'd0);
         end else begin
            e = q8.pop_front();
            chk("u8_data", 64'(d8), e.d);
            chk("u8_keep", 64'(k8), 64'(e.k));
            chk("u8_last", 64'(l8), 64'(e.l));
         end
      end
      p_stall = !rst && v8 && !r8;
      p_d     = d8;
      p_l     = l8;
   end

   initial begin
      int lim;
      sv16 = 0; sv64 = 0; sv8 = 0;
      r16 = 0; r64 = 0; r8 = 0;
      md = 2'd0;
      st = '0;
      rst = 1'b1;
      repeat (3) step();

      chk("rst_valid", 64'(v16), 64'd0);
      chk("rst_data", 64'(d16), 64'd0);
      chk("rst_keep", 64'(k16), 64'd0);
      chk("rst_last", 64'(l16), 64'd0);
      chk("rst_busy", 64'(b16), 64'd0);
      chk("rst_overrun", 64'(o16), 64'd0);
      rst = 1'b0;
      step();

      // SHA3-256("") lanes, DATA_WIDTH=16, ready held high.
      rand_st();
      st[0][0] = 64'h66d71ebff8c6ffa7;
      st[1][0] = 64'h62d661a05647c151;
      st[2][0] = 64'hfa493be44dff80f5;
      st[3][0] = 64'h4a43f8804b0ad882;
      md = 2'd1;
      r16 = 1;
      chk("t1_valid_pre", 64'(v16), 64'd0);
      sv16 = 1;
      exp_push(16);
      step();
      sv16 = 0;
      chk("t1_valid_lat", 64'(v16), 64'd1);
      chk("t1_beat0", 64'(d16), 64'hffa7);
      chk("t1_keep0", 64'(k16), 64'h3);
      chk("t1_busy", 64'(b16), 64'd1);
      drain(16);
      chk("t1_valid_post", 64'(v16), 64'd0);

      // 224-bit digest on 64-bit beats: partial last beat.
      rand_st();
      md = 2'd0;
      r64 = 1;
      sv64 = 1;
      exp_push(64);
      step();
      sv64 = 0;
      drain(64);
      chk("t2_valid_post", 64'(v64), 64'd0);

      // 512-bit digest on byte beats with random backpressure.
      rand_st();
      md = 2'd3;
      sv8 = 1;
      exp_push(8);
      step();
      sv8 = 0;
      drain(8);
      r8 = 0;
      step();
      chk("t3_valid_post", 64'(v8), 64'd0);

      // Dropped state mid-stream, then a chained capture on TLAST.
      rand_st();
      md = 2'd1;
      r16 = 1;
      sv16 = 1;
      exp_push(16);
      step();
      sv16 = 0;
      repeat (5) step();
      rand_st();
      sv16 = 1;
      step();
      sv16 = 0;
      chk("t4_overrun_hi", 64'(o16), 64'd1);
      step();
      chk("t4_overrun_lo", 64'(o16), 64'd0);
      lim = 0;
      while (!l16 && lim < 40) begin
         step();
         lim++;
      end
      chk("t4_tlast_seen", 64'(l16), 64'd1);
      rand_st();
      md = 2'd3;
      sv16 = 1;
      exp_push(16);
      step();
      sv16 = 0;
      chk("t4_b2b_valid", 64'(v16), 64'd1);
      chk("t4_b2b_overrun", 64'(o16), 64'd0);
      drain(16);

      // Reset during a stalled beat 3.
      rand_st();
      md = 2'd1;
      r16 = 1;
      sv16 = 1;
      exp_push(16);
      step();
      sv16 = 0;
      repeat (3) step();
      r16 = 0;
      rst = 1;
      step();
      chk("t5_valid", 64'(v16), 64'd0);
      chk("t5_data", 64'(d16), 64'd0);
      chk("t5_keep", 64'(k16), 64'd0);
      chk("t5_last", 64'(l16), 64'd0);
      chk("t5_busy", 64'(b16), 64'd0);
      chk("t5_overrun", 64'(o16), 64'd0);
      q16.delete();
      rst = 0;
      r16 = 1;
      rand_st();
      sv16 = 1;
      exp_push(16);
      step();
      sv16 = 0;
      drain(16);

      // Mode change during SEND must not alter the beat count.
      rand_st();
      md = 2'd1;
      sv16 = 1;
      exp_push(16);
      step();
      sv16 = 0;
      md = 2'd3;
      drain(16);
      repeat (2) step();
      chk("t6_valid_post", 64'(v16), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
